// File: rtl/lc3_regfile_pkg.sv
// rtl/lc3_regfile_pkg.sv - shared types and constants for the LC-3 multi-port register file
package lc3_regfile_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  localparam int CC_N = 2;
  localparam int CC_Z = 1;
  localparam int CC_P = 0;

  localparam logic [2:0] CC_RESET = 3'b010;

endpackage

// File: rtl/lc3_regfile_clear_seq.sv
// rtl/lc3_regfile_clear_seq.sv - post-reset clear sequencer sweeping every register address once
module lc3_regfile_clear_seq
  import lc3_regfile_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_busy,
  output logic              o_run,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_clr_we
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      // Last address written on this edge, so leave CLEAR and drop busy together.
      if (&cnt_q) begin
        state_d = ST_RUN;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_run      = (state_q == ST_RUN);
  assign o_clr_addr = cnt_q;
  assign o_clr_we   = (state_q == ST_CLEAR);

endmodule

// File: rtl/lc3_regfile_mp.sv
// rtl/lc3_regfile_mp.sv - parametrised multi-read-port register file with bypass, clear and NZP
module lc3_regfile_mp
  import lc3_regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     i_CLK,
  input  logic                     i_RST_N,
  input  logic                     i_LD_REG,
  input  logic                     i_LD_CC,
  input  logic [ADDR_W-1:0]        i_DR_Addr,
  input  logic [NUM_RD*ADDR_W-1:0] i_SR_Addr,
  input  logic [DATA_W-1:0]        i_bus,
  output logic [NUM_RD*DATA_W-1:0] o_SR,
  output logic [2:0]               o_NZP,
  output logic                     o_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              run;
  logic              seq_run;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [NUM_RD*DATA_W-1:0] sr_q, sr_d;
  logic [2:0]               nzp_q, nzp_d;
  logic [DATA_W-1:0]        rd_val [NUM_RD];

  lc3_regfile_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .i_clk     (i_CLK),
    .i_rst_n   (i_RST_N),
    .o_busy    (o_busy),
    .o_run     (seq_run),
    .o_clr_addr(clr_addr),
    .o_clr_we  (clr_we)
  );

  assign run = seq_run && i_RST_N;

  // Single write port shared between the clear sweep and normal loads.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = i_DR_Addr;
    wr_data = i_bus;
    if (i_RST_N) begin
      if (clr_we) begin
        wr_en   = 1'b1;
        wr_addr = clr_addr;
        wr_data = '0;
      end else if (i_LD_REG) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic              hit;
    assign rd_addr   = i_SR_Addr[k*ADDR_W +: ADDR_W];
    assign hit       = (BYPASS != 0) && i_LD_REG && (rd_addr == i_DR_Addr);
    assign rd_val[k] = hit ? i_bus : mem_q[rd_addr];
  end

  always_comb begin
    sr_d = '0;
    if (run) begin
      for (int k = 0; k < NUM_RD; k++) begin
        sr_d[k*DATA_W +: DATA_W] = rd_val[k];
      end
    end
  end

  always_comb begin
    nzp_d = nzp_q;
    if (run && i_LD_REG && i_LD_CC) begin
      nzp_d = '0;
      if (i_bus[DATA_W-1]) begin
        nzp_d[CC_N] = 1'b1;
      end else if (i_bus == '0) begin
        nzp_d[CC_Z] = 1'b1;
      end else begin
        nzp_d[CC_P] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      sr_q  <= '0;
      nzp_q <= CC_RESET;
    end else begin
      sr_q  <= sr_d;
      nzp_q <= nzp_d;
    end
  end

  assign o_SR  = sr_q;
  assign o_NZP = nzp_q;

endmodule

// File: tb/tb_lc3_regfile_mp.sv
// tb/tb_lc3_regfile_mp.sv - table-driven scoreboard bench for lc3_regfile_mp
module tb_lc3_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ld_reg, ld_cc;
  logic [2:0]  dr;
  logic [5:0]  sr_addr;
  logic [15:0] bus;
  logic [31:0] sr_a, sr_b;
  logic [2:0]  nzp_a, nzp_b;
  logic        busy_a, busy_b;

  logic        w_ld_reg, w_ld_cc;
  logic [3:0]  w_dr;
  logic [11:0] w_sr_addr;
  logic [31:0] w_bus;
  logic [95:0] w_sr;
  logic [2:0]  w_nzp;
  logic        w_busy;

  lc3_regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .BYPASS(1)) u_byp (
    .i_CLK(clk), .i_RST_N(rst_n), .i_LD_REG(ld_reg), .i_LD_CC(ld_cc),
    .i_DR_Addr(dr), .i_SR_Addr(sr_addr), .i_bus(bus),
    .o_SR(sr_a), .o_NZP(nzp_a), .o_busy(busy_a)
  );

  lc3_regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .BYPASS(0)) u_nb (
    .i_CLK(clk), .i_RST_N(rst_n), .i_LD_REG(ld_reg), .i_LD_CC(ld_cc),
    .i_DR_Addr(dr), .i_SR_Addr(sr_addr), .i_bus(bus),
    .o_SR(sr_b), .o_NZP(nzp_b), .o_busy(busy_b)
  );

  lc3_regfile_mp #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .BYPASS(1)) u_wide (
    .i_CLK(clk), .i_RST_N(rst_n), .i_LD_REG(w_ld_reg), .i_LD_CC(w_ld_cc),
    .i_DR_Addr(w_dr), .i_SR_Addr(w_sr_addr), .i_bus(w_bus),
    .o_SR(w_sr), .o_NZP(w_nzp), .o_busy(w_busy)
  );

  typedef struct {
    logic        ld_reg;
    logic        ld_cc;
    logic [2:0]  dr;
    logic [2:0]  s0;
    logic [2:0]  s1;
    logic [15:0] bus;
    logic [15:0] byp0;
    logic [15:0] byp1;
    logic [15:0] nb0;
    logic [15:0] nb1;
    logic [2:0]  nzp;
  } vec_t;

  typedef struct {
    logic [15:0] byp0;
    logic [15:0] byp1;
    logic [15:0] nb0;
    logic [15:0] nb1;
    logic [2:0]  nzp;
  } exp_t;

  vec_t tbl [10];
  exp_t sb [$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   fall_a, fall_b, fall_w, fall_m;
    exp_t e;

    tbl[0] = '{1'b0, 1'b0, 3'd0, 3'd3, 3'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b010};
    tbl[1] = '{1'b0, 1'b0, 3'd0, 3'd0, 3'd7, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b010};
    tbl[2] = '{1'b1, 1'b0, 3'd5, 3'd5, 3'd5, 16'h1234, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 3'b010};
    tbl[3] = '{1'b0, 1'b0, 3'd0, 3'd5, 3'd5, 16'h0000, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 3'b010};
    tbl[4] = '{1'b1, 1'b1, 3'd1, 3'd1, 3'd5, 16'h8000, 16'h8000, 16'h1234, 16'h0000, 16'h1234, 3'b100};
    tbl[5] = '{1'b1, 1'b1, 3'd2, 3'd1, 3'd2, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 3'b010};
    tbl[6] = '{1'b1, 1'b1, 3'd6, 3'd6, 3'd1, 16'h0007, 16'h0007, 16'h8000, 16'h0000, 16'h8000, 3'b001};
    tbl[7] = '{1'b0, 1'b1, 3'd6, 3'd6, 3'd6, 16'h8000, 16'h0007, 16'h0007, 16'h0007, 16'h0007, 3'b001};
    tbl[8] = '{1'b1, 1'b0, 3'd7, 3'd7, 3'd0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 3'b001};
    tbl[9] = '{1'b1, 1'b1, 3'd0, 3'd7, 3'd0, 16'h00FF, 16'hFFFF, 16'h00FF, 16'hFFFF, 16'h0000, 3'b001};

    rst_n = 1'b0; ld_reg = 1'b0; ld_cc = 1'b0; dr = '0; sr_addr = '0; bus = '0;
    w_ld_reg = 1'b0; w_ld_cc = 1'b0; w_dr = '0; w_sr_addr = '0; w_bus = '0;

    tick();
    tick();
    chk("rst_sr_a", sr_a, 0);
    chk("rst_nzp_a", nzp_a, 3'b010);
    chk("rst_busy_a", busy_a, 1);
    chk("rst_nzp_b", nzp_b, 3'b010);
    chk("rst_busy_w", w_busy, 1);
    chk("rst_sr_w", w_sr, 0);

    // Release reset and try to write during the clear on every instance.
    @(negedge clk);
    rst_n = 1'b1;
    ld_reg = 1'b1; ld_cc = 1'b1; dr = 3'd3; bus = 16'hBEEF; sr_addr = {3'd3, 3'd3};
    w_ld_reg = 1'b1; w_ld_cc = 1'b1; w_dr = 4'd3; w_bus = 32'hDEAD_BEEF; w_sr_addr = {4'd3, 4'd3, 4'd3};
    fall_a = 0; fall_b = 0; fall_w = 0;
    for (int ed = 1; ed <= 24; ed++) begin
      @(posedge clk);
      #1;
      if (busy_a === 1'b0 && fall_a == 0) fall_a = ed;
      if (busy_b === 1'b0 && fall_b == 0) fall_b = ed;
      if (w_busy === 1'b0 && fall_w == 0) fall_w = ed;
      if (ed <= 4) begin
        chk("clear_sr_a_zero", sr_a, 0);
        chk("clear_sr_w_zero", w_sr, 0);
      end
      if (ed == 4) begin
        ld_reg = 1'b0; ld_cc = 1'b0; w_ld_reg = 1'b0; w_ld_cc = 1'b0;
      end
    end
    chk("busy_cycles_a", fall_a, 8);
    chk("busy_cycles_b", fall_b, 8);
    chk("busy_cycles_w", fall_w, 16);
    chk("nzp_after_clear_a", nzp_a, 3'b010);
    chk("nzp_after_clear_w", w_nzp, 3'b010);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ld_reg  = tbl[i].ld_reg;
      ld_cc   = tbl[i].ld_cc;
      dr      = tbl[i].dr;
      sr_addr = {tbl[i].s1, tbl[i].s0};
      bus     = tbl[i].bus;
      sb.push_back('{tbl[i].byp0, tbl[i].byp1, tbl[i].nb0, tbl[i].nb1, tbl[i].nzp});
      tick();
      e = sb.pop_front();
      chk($sformatf("v%0d_byp_p0", i), sr_a[15:0], e.byp0);
      chk($sformatf("v%0d_byp_p1", i), sr_a[31:16], e.byp1);
      chk($sformatf("v%0d_nb_p0", i), sr_b[15:0], e.nb0);
      chk($sformatf("v%0d_nb_p1", i), sr_b[31:16], e.nb1);
      chk($sformatf("v%0d_nzp_byp", i), nzp_a, e.nzp);
      chk($sformatf("v%0d_nzp_nb", i), nzp_b, e.nzp);
    end

    @(negedge clk);
    ld_reg = 1'b0; ld_cc = 1'b0;
    w_ld_reg = 1'b1; w_ld_cc = 1'b1; w_dr = 4'd15; w_bus = 32'hFFFF_FFFF;
    w_sr_addr = {4'd15, 4'd15, 4'd15};
    tick();
    chk("wide_byp_all", w_sr, {3{32'hFFFF_FFFF}});
    chk("wide_nzp", w_nzp, 3'b100);
    @(negedge clk);
    w_ld_reg = 1'b0; w_ld_cc = 1'b0; w_sr_addr = {4'd15, 4'd3, 4'd15};
    tick();
    chk("wide_read_back", w_sr, {32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF});
    chk("wide_nzp_hold", w_nzp, 3'b100);

    // Reset, then reset again four edges into the clear.
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    chk("rerst_nzp_a", nzp_a, 3'b010);
    chk("rerst_sr_a", sr_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("midclear_busy", busy_a, 1);
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    fall_m = 0;
    for (int ed = 1; ed <= 30; ed++) begin
      @(posedge clk);
      #1;
      if (busy_a === 1'b0) begin
        fall_m = ed;
        break;
      end
    end
    chk("midclear_busy_cycles", fall_m, 8);
    @(negedge clk);
    sr_addr = {3'd0, 3'd5};
    tick();
    chk("midclear_r5_cleared", sr_a[15:0], 16'h0000);
    chk("midclear_r0_cleared", sr_a[31:16], 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lc3_regfile_mp.md
# lc3_regfile_mp

Parametrised multi-port register file for the LC-3 datapath and its successors. It generalises the 8x16 two-read-port file to configurable data width, register count and read-port count. It adds a selectable write-to-read bypass, a hardware clear sequence after reset, and an NZP condition-code register updated from written data. It sits between the decode/control-store stage (addresses, load enables) and the ALU/bus (read data).

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write forwarded to matching read port; 0 = read returns pre-write value

Ports:
- i_CLK  input  1  clock; all state updates on rising edge
- i_RST_N  input  1  reset; synchronous and active-low
- i_LD_REG  input  1  write enable
- i_LD_CC  input  1  update condition codes from i_bus; honoured only together with i_LD_REG
- i_DR_Addr  input  ADDR_W  destination register address
- i_SR_Addr  input  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- i_bus  input  DATA_W  write data
- o_SR  output  NUM_RD*DATA_W  packed registered read data; port k uses bits [k*DATA_W +: DATA_W]
- o_NZP  output  3  condition codes {N,Z,P}
- o_busy  output  1  high while the clear sequence runs

## Operation
- FSM with two states, CLEAR and RUN:
  - Reset forces CLEAR, clear counter = 0, o_SR = 0, o_NZP = 3'b010, o_busy = 1.
  - CLEAR: each cycle, write 0 to register[counter], then increment the counter.
  - After the write to register 2**ADDR_W-1, move to RUN and deassert o_busy on that same edge.
  - Clear takes exactly 2**ADDR_W cycles.
- In CLEAR:
  - i_LD_REG and i_LD_CC are ignored.
  - o_SR is held at 0.
- In RUN, every edge:
  - Each o_SR port k is loaded with register[addr_k].
  - If i_LD_REG, register[i_DR_Addr] <= i_bus.
  - If BYPASS=1 and i_LD_REG and addr_k == i_DR_Addr, port k loads i_bus instead of the stored value.
  - If BYPASS=0, port k gets the old value; the new value is visible from the next read.
- Condition codes:
  - On i_LD_REG && i_LD_CC in RUN, o_NZP <= {i_bus[DATA_W-1], i_bus==0, !i_bus[DATA_W-1] && i_bus!=0}.
  - Exactly one bit is ever set.
  - i_LD_CC without i_LD_REG has no effect.
- Multiple read ports may address the same register; all return identical data.
- Reset asserted mid-operation (any state, including mid-clear):
  - Restarts the clear from counter 0 on the next edge.
  - Register contents are not preserved.

## Timing
- Read latency: 1 cycle. Address presented at edge t produces o_SR valid after edge t.
- Write latency: 1 cycle. Data is stored at edge t and readable via a non-bypassed read issued at t+1, with data out after t+1.
- o_NZP is valid the cycle after the qualifying write.
- o_busy falls exactly 2**ADDR_W cycles after the first edge with i_RST_N=1. With default parameters, the reset edge is followed by 8 clear edges.
- No combinational path from any input to any output.

## Structure
- Package lc3_regfile_pkg holds:
  - FSM state enum {ST_CLEAR, ST_RUN}
  - NZP bit indices (CC_N=2, CC_Z=1, CC_P=0)
  - the reset CC constant 3'b010
- One sub-module, lc3_regfile_clear_seq: the clear counter and FSM, outputting busy, clear address and clear-write strobe.
- Storage is an inferred distributed-RAM array with NUM_RD read ports.
- Write-port muxing between clear and run, and the bypass compare, sit in the top module, generated per read port.

## Test plan
- Reset then clear:
  - Stimulus: hold i_RST_N=0 for 2 cycles, release, pre-load garbage is irrelevant.
  - Response: o_busy high for exactly 8 cycles, o_NZP=3'b010, every register reads 16'h0000.
- Writes ignored during clear: pulse i_LD_REG with R3=16'hBEEF while o_busy=1 -> after clear, R3 reads 16'h0000.
- Bypass on: BYPASS=1, write R5=16'h1234 while port 0 and port 1 both address R5 -> both o_SR ports show 16'h1234 after that edge.
- Bypass off: BYPASS=0, same stimulus -> both ports show 16'h0000, then 16'h1234 on the next read.
- Condition codes, with i_LD_REG=i_LD_CC=1:
  - write 16'h8000 -> o_NZP=3'b100
  - write 16'h0000 -> 3'b010
  - write 16'h0007 -> 3'b001
  - then i_LD_CC=1 with i_LD_REG=0 and 16'h8000 -> o_NZP stays 3'b001
- Mid-clear reset: assert i_RST_N=0 for 1 cycle at clear cycle 4 -> clear restarts, o_busy stays high a further 8 cycles.
- Parameter sweep: DATA_W=32, ADDR_W=4, NUM_RD=3, write R15=32'hFFFF_FFFF, read it on all three ports -> all show 32'hFFFF_FFFF and o_NZP=3'b100.
